dsp_encode: RTL and testbench
=============================

Name: dsp_encode

Overview:
- Packs instruction fields (opcode, registers, immediate) into 32-bit DSP instruction words.
- Writes the packed words sequentially into instruction memory.
- Is the inverse of the instruction decode stage; used by the program loader and test infrastructure to build programs in hardware.
- Rejects opcodes the decoder does not define, so no word is ever written that the decoder would halt on.

Parameters:
- INST_W, `INST_WORD_LEN (32), instruction word width
- RADDR_W, `REG_ADDR_LEN (5), register address width
- MADDR_W, `MEM_ADDR_LEN, instruction memory address width
- IMM_W, 16, immediate/branch target field width (bits [15:0])

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse in IDLE: begin a program load
- abort  in  1  pulse: terminate load, drop pending word
- base_addr  in  MADDR_W  first write address, sampled on start
- len  in  MADDR_W+1  number of instructions to write, sampled on start
- in_valid  in  1  field set valid
- in_ready  out  1  field set accepted when in_valid&in_ready
- in_opcode  in  6  opcode
- in_rs1  in  RADDR_W  source 1
- in_rs2  in  RADDR_W  source 2
- in_rd  in  RADDR_W  destination
- in_imm  in  IMM_W  immediate / target
- imem_we  out  1  write strobe, held until imem_ready
- imem_addr  out  MADDR_W  write address
- imem_wdata  out  INST_W  encoded word
- imem_ready  in  1  memory accepts the write this cycle
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of load (success or error)
- err  out  1  sticky illegal-opcode flag; cleared on start
- err_index  out  MADDR_W+1  index (0-based) of the offending instruction

Behaviour:
- Reset (async, rst_n low): state=IDLE; in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, busy=0, done=0, err=0, err_index=0.
- FSM states: IDLE, RUN, DRAIN, ERR.
- IDLE:
  - start -> RUN; wr_addr=base_addr; remaining=len; idx=0; err=0.
  - start with len=0 -> done pulse next cycle; stay IDLE.
- RUN:
  - in_ready = (remaining!=0) & (!imem_we | imem_ready).
  - On an accepted legal word: next cycle imem_we=1, imem_addr=wr_addr, imem_wdata=encoded word. Then wr_addr+1 (wraps mod 2^MADDR_W), remaining-1, idx+1.
  - Latency: exactly 1 cycle from accept to imem_we, with full throughput of 1 word/cycle while imem_ready=1.
  - imem_we/addr/wdata stay stable while imem_ready=0.
  - remaining reaches 0 -> DRAIN.
- DRAIN: in_ready=0; when no write is pending (or the pending write completes with imem_ready), done pulse -> IDLE.
- Illegal opcode on accept:
  - No write is generated for it; err=1, err_index=idx -> ERR.
  - A pending earlier write still completes.
  - ERR: in_ready=0; once the pending write drains, done pulse -> IDLE.
- abort in RUN/DRAIN/ERR:
  - Next cycle: imem_we=0, any pending write dropped, state=IDLE, done pulse; err retained.
  - abort and start in the same cycle: abort wins.
- start outside IDLE: ignored.
- Legal opcodes:
  - R-type: 0x00-0x0D, 0x10-0x1B, 0x32 (LD), 0x34 (LD_IMM).
  - Non-R: 0x20-0x23, 0x30, 0x31, 0x33.
  - All others are illegal.
- Encoding:
  - R-type: {op, rs1, rs2, rd, 5'b0, 6'b0}.
  - Non-R: {op, rs1, f, imm}, where f=in_rd for POP (0x31) and f=in_rs2 otherwise.
  - Unused input fields are ignored.

Decomposition:
- Shared package (definitions): opcode constants OP_ADD..OP_LD_IMM, field bit positions (OP_MSB=31, RS1_LSB=21, RS2_LSB=16, RD_LSB=11, IMM_LSB=0), FSM state encodings.
- One natural sub-module: dsp_encode_pack, purely combinational (fields -> word, legal, r_type). Shares its opcode table with the decode stage.

Test Plan:
- start base=0x10 len=1; ADD op=0x00 rs1=1 rs2=2 rd=3 -> cycle+1: imem_we=1, addr=0x10, wdata=0x00221800; then done, err=0.
- len=3 back-to-back: JMP imm=0x0040; POP rd=7; LD_IMM rs1=4 rd=9. imem_ready held low 2 cycles on the first write -> writes 0x80000040 @0x10, 0xC4070000 @0x11, 0xD0804800 @0x12, in order, with wdata stable while stalled.
- base=2^MADDR_W-1, len=2 -> second write at address 0 (wrap).
- len=3, second opcode=0x0E -> exactly one write, err=1, err_index=1, done pulse, in_ready=0 afterward.
- abort while imem_we=1 and imem_ready=0 -> next cycle imem_we=0, done=1, busy=0.
- len=0 start -> done pulse, no writes; rst_n low mid-RUN -> all outputs to reset values immediately.

Source files
------------

// File: rtl/dsp_encode_pkg.sv
// Shared definitions for the DSP instruction encoder: widths, field layout, opcode table.
package dsp_encode_pkg;

    localparam int unsigned INST_W  = 32;
    localparam int unsigned RADDR_W = 5;
    localparam int unsigned MADDR_W = 8;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned CNT_W   = MADDR_W + 1;

    localparam int unsigned OP_MSB  = 31;
    localparam int unsigned RS1_LSB = 21;
    localparam int unsigned RS2_LSB = 16;
    localparam int unsigned RD_LSB  = 11;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [OP_W-1:0] OP_ADD       = 6'h00;
    localparam logic [OP_W-1:0] OP_ALU_LAST  = 6'h0D;
    localparam logic [OP_W-1:0] OP_DSP_FIRST = 6'h10;
    localparam logic [OP_W-1:0] OP_DSP_LAST  = 6'h1B;
    localparam logic [OP_W-1:0] OP_JMP       = 6'h20;
    localparam logic [OP_W-1:0] OP_BR_LAST   = 6'h23;
    localparam logic [OP_W-1:0] OP_ST        = 6'h30;
    localparam logic [OP_W-1:0] OP_POP       = 6'h31;
    localparam logic [OP_W-1:0] OP_LD        = 6'h32;
    localparam logic [OP_W-1:0] OP_PUSH      = 6'h33;
    localparam logic [OP_W-1:0] OP_LD_IMM    = 6'h34;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ERR   = 2'd3
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0]    opcode;
        logic [RADDR_W-1:0] rs1;
        logic [RADDR_W-1:0] rs2;
        logic [RADDR_W-1:0] rd;
        logic [IMM_W-1:0]   imm;
    } fields_t;

    // Register-format opcodes (three register fields, no immediate).
    function automatic logic op_is_r(input logic [OP_W-1:0] op);
        return (op <= OP_ALU_LAST) || ((op >= OP_DSP_FIRST) && (op <= OP_DSP_LAST)) ||
               (op == OP_LD) || (op == OP_LD_IMM);
    endfunction

    // Immediate/branch-format opcodes.
    function automatic logic op_is_nr(input logic [OP_W-1:0] op);
        return ((op >= OP_JMP) && (op <= OP_BR_LAST)) ||
               (op == OP_ST) || (op == OP_POP) || (op == OP_PUSH);
    endfunction

endpackage

// File: rtl/dsp_encode_pack.sv
// Combinational field packer: instruction fields -> 32-bit word plus legality.
module dsp_encode_pack
    import dsp_encode_pkg::*;
(
    input  fields_t             fields_i,
    output logic [INST_W-1:0]   word_o,
    output logic                legal_o
);

    logic r_type_c;

    // Place fields at their decoder bit positions; POP carries rd in the rs2 slot.
    always_comb begin
        r_type_c = op_is_r(fields_i.opcode);
        legal_o  = r_type_c | op_is_nr(fields_i.opcode);
        word_o   = '0;
        word_o[OP_MSB -: OP_W]      = fields_i.opcode;
        word_o[RS1_LSB +: RADDR_W]  = fields_i.rs1;
        if (r_type_c) begin
            word_o[RS2_LSB +: RADDR_W] = fields_i.rs2;
            word_o[RD_LSB +: RADDR_W]  = fields_i.rd;
        end else begin
            word_o[RS2_LSB +: RADDR_W] = (fields_i.opcode == OP_POP) ? fields_i.rd : fields_i.rs2;
            word_o[IMM_LSB +: IMM_W]   = fields_i.imm;
        end
    end

endmodule

// File: rtl/dsp_encode.sv
// Program loader: packs field sets into instruction words and writes them to instruction memory.
module dsp_encode
    import dsp_encode_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [MADDR_W-1:0]  base_addr,
    input  logic [CNT_W-1:0]    len,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OP_W-1:0]     in_opcode,
    input  logic [RADDR_W-1:0]  in_rs1,
    input  logic [RADDR_W-1:0]  in_rs2,
    input  logic [RADDR_W-1:0]  in_rd,
    input  logic [IMM_W-1:0]    in_imm,
    output logic                imem_we,
    output logic [MADDR_W-1:0]  imem_addr,
    output logic [INST_W-1:0]   imem_wdata,
    input  logic                imem_ready,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [CNT_W-1:0]    err_index
);

    state_e              state_q, state_d;
    logic [MADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic                we_q, we_d;
    logic [MADDR_W-1:0]  addr_q, addr_d;
    logic [INST_W-1:0]   wdata_q, wdata_d;
    logic                busy_q;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    err_index_q, err_index_d;
    logic                in_ready_c;

    fields_t             fields_c;
    logic [INST_W-1:0]   word_c;
    logic                legal_c;

    assign fields_c = {in_opcode, in_rs1, in_rs2, in_rd, in_imm};

    dsp_encode_pack u_pack (
        .fields_i (fields_c),
        .word_o   (word_c),
        .legal_o  (legal_c)
    );

    // Next-state and datapath update; abort overrides everything outside IDLE.
    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        remaining_d = remaining_q;
        idx_d       = idx_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        done_d      = 1'b0;
        err_d       = err_q;
        err_index_d = err_index_q;
        in_ready_c  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    err_d       = 1'b0;
                    wr_addr_d   = base_addr;
                    remaining_d = len;
                    idx_d       = '0;
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                in_ready_c = (remaining_q != '0) && (!we_q || imem_ready);
                if (we_q && imem_ready) begin
                    we_d = 1'b0;
                end
                if (in_valid && in_ready_c) begin
                    if (legal_c) begin
                        we_d        = 1'b1;
                        addr_d      = wr_addr_q;
                        wdata_d     = word_c;
                        wr_addr_d   = wr_addr_q + MADDR_W'(1);
                        remaining_d = remaining_q - CNT_W'(1);
                        idx_d       = idx_q + CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            state_d = ST_DRAIN;
                        end
                    end else begin
                        err_d       = 1'b1;
                        err_index_d = idx_q;
                        state_d     = ST_ERR;
                    end
                end
            end
            ST_DRAIN, ST_ERR: begin
                if (!we_q || imem_ready) begin
                    we_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            we_d    = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_q   <= '0;
            remaining_q <= '0;
            idx_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_index_q <= '0;
        end else begin
            wr_addr_q   <= wr_addr_d;
            remaining_q <= remaining_d;
            idx_q       <= idx_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= done_d;
            err_q       <= err_d;
            err_index_q <= err_index_d;
        end
    end

    assign in_ready   = in_ready_c;
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign err_index  = err_index_q;

endmodule

// File: tb/tb_dsp_encode.sv
// Scoreboard bench for dsp_encode with a behavioural encoding/legality model.
module tb_dsp_encode;
    import dsp_encode_pkg::MADDR_W;

    localparam int unsigned AW = MADDR_W;

    typedef struct {
        logic [5:0]  op;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [15:0] imm;
    } instr_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort;
    logic [AW-1:0] base_addr;
    logic [AW:0]   len;
    logic          in_valid, in_ready;
    logic [5:0]    in_opcode;
    logic [4:0]    in_rs1, in_rs2, in_rd;
    logic [15:0]   in_imm;
    logic          imem_we, imem_ready;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          busy, done, err;
    logic [AW:0]   err_index;

    int     checks = 0;
    int     errors = 0;
    instr_t prog_q[$];
    wr_t    sb_q[$];
    bit     rand_rdy = 1'b0;
    int     stall_cnt = 0;

    dsp_encode dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .len        (len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_rd      (in_rd),
        .in_imm     (in_imm),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .imem_ready (imem_ready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_index  (err_index)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Decoder-defined opcodes, by numeric range.
    function automatic bit m_legal(input logic [5:0] op);
        int o = int'(op);
        return (o <= 13) || (o >= 16 && o <= 27) || (o >= 32 && o <= 35) || (o >= 48 && o <= 52);
    endfunction

    // Instruction word as arithmetic sum of shifted fields.
    function automatic logic [31:0] m_encode(input instr_t i);
        longint o = longint'(i.op);
        bit     r = (o <= 13) || (o >= 16 && o <= 27) || (o == 50) || (o == 52);
        longint w = o * (64'd1 << 26) + longint'(i.rs1) * (64'd1 << 21);
        if (r) w += longint'(i.rs2) * (64'd1 << 16) + longint'(i.rd) * (64'd1 << 11);
        else   w += longint'((o == 49) ? i.rd : i.rs2) * (64'd1 << 16) + longint'(i.imm);
        return 32'(w);
    endfunction

    function automatic instr_t rand_instr(input bit want_legal);
        instr_t i;
        do i.op = 6'($urandom); while (m_legal(i.op) != want_legal);
        i.rs1 = 5'($urandom);
        i.rs2 = 5'($urandom);
        i.rd  = 5'($urandom);
        i.imm = 16'($urandom);
        return i;
    endfunction

    task automatic drive_fields(input instr_t i);
        in_opcode = i.op;
        in_rs1    = i.rs1;
        in_rs2    = i.rs2;
        in_rd     = i.rd;
        in_imm    = i.imm;
    endtask

    // Memory-side ready: forced stalls first, then random or always-ready.
    initial begin
        imem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_cnt > 0) begin
                imem_ready = 1'b0;
                if (imem_we) stall_cnt--;
            end else if (rand_rdy) begin
                imem_ready = ($urandom_range(0, 3) != 0);
            end else begin
                imem_ready = 1'b1;
            end
        end
    end

    // Monitor: compare each completed write with the scoreboard and hold stalled writes stable.
    initial begin
        bit            have_prev = 1'b0;
        logic [AW-1:0] pa;
        logic [31:0]   pd;
        wr_t           e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have_prev = 1'b0;
            end else begin
                if (have_prev) begin
                    check("stall_we", 32'(imem_we), 32'd1);
                    check("stall_addr", 32'(imem_addr), 32'(pa));
                    check("stall_data", imem_wdata, pd);
                end
                have_prev = 1'b0;
                if (imem_we && imem_ready) begin
                    check("write_expected", 32'(sb_q.size() != 0), 32'd1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check("wr_addr", 32'(imem_addr), 32'(e.addr));
                        check("wr_data", imem_wdata, e.data);
                    end
                end else if (imem_we && !abort) begin
                    have_prev = 1'b1;
                    pa = imem_addr;
                    pd = imem_wdata;
                end
            end
        end
    end

    // One program load from prog_q; pushes expected writes as each field set is accepted.
    task automatic run_load(input logic [AW-1:0] base, input bit no_stall_expected);
        int  n = prog_q.size();
        int  bad = -1;
        int  stalls = 0;
        int  waited;
        bit  got;
        wr_t e;
        @(posedge clk); #1;
        base_addr = base;
        len       = (AW+1)'(n);
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            drive_fields(prog_q[k]);
            in_valid = 1'b1;
            got = 1'b0;
            waited = 0;
            while (!got && waited < 200) begin
                @(negedge clk);
                if (in_ready) got = 1'b1;
                else waited++;
                @(posedge clk); #1;
            end
            stalls += waited;
            check("accept_in_time", 32'(got), 32'd1);
            if (!got) break;
            if (!m_legal(prog_q[k].op)) begin
                bad = k;
                break;
            end
            e.addr = base + AW'(k);
            e.data = m_encode(prog_q[k]);
            sb_q.push_back(e);
            check("lat_we", 32'(imem_we), 32'd1);
            check("lat_addr", 32'(imem_addr), 32'(e.addr));
            check("lat_data", imem_wdata, e.data);
            check("busy_run", 32'(busy), 32'd1);
        end
        in_valid = 1'b0;
        if (bad >= 0) begin
            @(negedge clk);
            check("in_ready_after_err", 32'(in_ready), 32'd0);
        end
        got = 1'b0;
        waited = 0;
        while (!got && waited < 300) begin
            @(negedge clk);
            if (done) got = 1'b1;
            else waited++;
        end
        check("done_seen", 32'(got), 32'd1);
        if (n == 0) check("len0_done_latency", 32'(waited), 32'd0);
        check("err", 32'(err), 32'(bad >= 0));
        if (bad >= 0) check("err_index", 32'(err_index), 32'(bad));
        check("busy_at_done", 32'(busy), 32'd0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        if (no_stall_expected) check("throughput_stalls", 32'(stalls), 32'd0);
        prog_q.delete();
    endtask

    initial begin
        instr_t i;
        #200000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1);
        i = rand_instr(1'b1);
    end

    initial begin
        instr_t i;
        int     n;
        int     bad_at;
        start = 0; abort = 0; base_addr = '0; len = '0; in_valid = 0;
        in_opcode = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_imm = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_index", 32'(err_index), 32'd0);
        rst_n = 1'b1;

        // Single ADD.
        prog_q.push_back('{op: 6'h00, rs1: 5'd1, rs2: 5'd2, rd: 5'd3, imm: 16'h0});
        run_load(8'h10, 1'b1);

        // JMP / POP / LD_IMM with the first write stalled two cycles.
        stall_cnt = 2;
        prog_q.push_back('{op: 6'h20, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, imm: 16'h0040});
        prog_q.push_back('{op: 6'h31, rs1: 5'd0, rs2: 5'd0, rd: 5'd7, imm: 16'h0});
        prog_q.push_back('{op: 6'h34, rs1: 5'd4, rs2: 5'd0, rd: 5'd9, imm: 16'h0});
        run_load(8'h10, 1'b0);

        // Address wrap.
        prog_q.push_back(rand_instr(1'b1));
        prog_q.push_back(rand_instr(1'b1));
        run_load(8'hFF, 1'b1);

        // Illegal second opcode.
        prog_q.push_back(rand_instr(1'b1));
        prog_q.push_back('{op: 6'h0E, rs1: 5'd1, rs2: 5'd1, rd: 5'd1, imm: 16'h1});
        prog_q.push_back(rand_instr(1'b1));
        run_load(8'h20, 1'b0);

        // Full throughput with memory always ready.
        for (int k = 0; k < 5; k++) prog_q.push_back(rand_instr(1'b1));
        run_load(8'h80, 1'b1);

        // Zero-length load.
        run_load(8'h33, 1'b0);

        // Abort while a write is stalled.
        stall_cnt = 1000;
        @(posedge clk); #1;
        base_addr = 8'h40; len = 9'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drive_fields(rand_instr(1'b1));
        in_valid = 1'b1;
        @(negedge clk);
        check("abort_pre_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        check("abort_we_pending", 32'(imem_we), 32'd1);
        check("abort_mem_stalled", 32'(imem_ready), 32'd0);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_we", 32'(imem_we), 32'd0);
        check("abort_done", 32'(done), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        stall_cnt = 0;
        @(negedge clk);
        check("abort_done_one_cycle", 32'(done), 32'd0);

        // Reset asserted in the middle of a load.
        stall_cnt = 1000;
        @(posedge clk); #1;
        base_addr = 8'h50; len = 9'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        drive_fields(rand_instr(1'b1));
        in_valid = 1'b1;
        @(posedge clk); #2;
        check("midrun_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_imem_we", 32'(imem_we), 32'd0);
        check("midrst_imem_addr", 32'(imem_addr), 32'd0);
        check("midrst_imem_wdata", imem_wdata, 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        in_valid = 1'b0;
        sb_q.delete();
        stall_cnt = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Randomised loads, some with an illegal opcode at a random index.
        for (int t = 0; t < 25; t++) begin
            rand_rdy = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 8);
            bad_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            for (int k = 0; k < n; k++) prog_q.push_back(rand_instr(k != bad_at));
            run_load(8'($urandom), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
